// File: rtl/csr_if.sv
// Request/response bundle between the execute stage and the CSR file.
//   io_req_*        : one CSR request, held valid until io_resp_valid
//   io_retire       : one pulse per retired instruction
//   io_busy         : CSR file is working on a request
//   io_resp_*       : one-cycle response strobe plus held old value / illegal flag
// slave  : the CSR file side
// master : the execute-stage side
interface csr_if;
    logic        io_req_valid;
    logic [2:0]  io_req_funct3;
    logic [11:0] io_req_addr;
    logic [4:0]  io_req_rs1_idx;
    logic [31:0] io_req_rs1_data;
    logic        io_retire;
    logic        io_busy;
    logic        io_resp_valid;
    logic [31:0] io_resp_rdata;
    logic        io_resp_illegal;

    modport slave (
        input  io_req_valid, io_req_funct3, io_req_addr, io_req_rs1_idx,
               io_req_rs1_data, io_retire,
        output io_busy, io_resp_valid, io_resp_rdata, io_resp_illegal
    );

    modport master (
        output io_req_valid, io_req_funct3, io_req_addr, io_req_rs1_idx,
               io_req_rs1_data, io_retire,
        input  io_busy, io_resp_valid, io_resp_rdata, io_resp_illegal
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file for the RV32I core.
// Executes CSRRW/RS/RC and their immediate forms as a three-state
// read-modify-write (IDLE -> ACCESS -> RESP), returns the old CSR value and
// keeps the 64-bit mcycle / minstret counters.
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : csr_if.slave (request, retire pulse, busy, response)
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic  clock,
    input  logic  reset,
    csr_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched request
    logic [2:0]  funct3_reg;
    logic [11:0] addr_reg;
    logic [4:0]  rs1_idx_reg;
    logic [31:0] rs1_data_reg;

    // Results computed in ACCESS, used in RESP
    logic [31:0] rdata_reg;
    logic        illegal_reg;
    logic [31:0] wdata_reg;
    logic        wen_reg;

    // Architectural state
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [63:0] mcycle_reg, mcycle_next;
    logic [63:0] minstret_reg, minstret_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.io_req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Decode of the latched request
    // ------------------------------------------------------------------
    logic        mapped;
    logic        is_counter;
    logic [31:0] old_val;
    logic [31:0] src;
    logic        suppress;
    logic        illegal;
    logic [31:0] new_val;

    always_comb begin
        mapped     = 1'b1;
        is_counter = 1'b0;
        old_val    = 32'h0;
        case (addr_reg)
            12'h305: old_val = mtvec_reg;
            12'h340: old_val = mscratch_reg;
            12'h341: old_val = mepc_reg;
            12'h342: old_val = mcause_reg;
            12'hB00, 12'hC00: begin old_val = mcycle_reg[31:0];    is_counter = 1'b1; end
            12'hB80, 12'hC80: begin old_val = mcycle_reg[63:32];   is_counter = 1'b1; end
            12'hB02, 12'hC02: begin old_val = minstret_reg[31:0];  is_counter = 1'b1; end
            12'hB82, 12'hC82: begin old_val = minstret_reg[63:32]; is_counter = 1'b1; end
            default: mapped = 1'b0;
        endcase
    end

    // funct3[2] selects the zero-extended rs1 index as the operand;
    // funct3[1:0] is the operation class (01 write, 10 set, 11 clear).
    assign src      = funct3_reg[2] ? {27'b0, rs1_idx_reg} : rs1_data_reg;
    assign suppress = (funct3_reg[1:0] != 2'b01) && (rs1_idx_reg == 5'd0);
    assign illegal  = (funct3_reg[1:0] == 2'b00)
                   || !mapped
                   || ((addr_reg[11:10] == 2'b11) && !suppress)
                   || (is_counter && !COUNTERS_EN);

    always_comb begin
        new_val = old_val;
        case (funct3_reg[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            funct3_reg   <= 3'd0;
            addr_reg     <= 12'd0;
            rs1_idx_reg  <= 5'd0;
            rs1_data_reg <= 32'd0;
            rdata_reg    <= 32'd0;
            illegal_reg  <= 1'b0;
            wdata_reg    <= 32'd0;
            wen_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && bus.io_req_valid) begin
                funct3_reg   <= bus.io_req_funct3;
                addr_reg     <= bus.io_req_addr;
                rs1_idx_reg  <= bus.io_req_rs1_idx;
                rs1_data_reg <= bus.io_req_rs1_data;
            end
            // rdata/illegal only change on the edge into RESP, so they hold
            // between responses.
            if (state_reg == ACCESS) begin
                rdata_reg   <= illegal ? 32'd0 : old_val;
                illegal_reg <= illegal;
                wdata_reg   <= new_val;
                wen_reg     <= !illegal && !suppress;
            end
        end
    end

    // ------------------------------------------------------------------
    // CSR write commit (edge ending RESP)
    // ------------------------------------------------------------------
    logic commit;
    assign commit = (state_reg == RESP) && wen_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtvec_reg    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_reg <= 32'd0;
            mepc_reg     <= 32'd0;
            mcause_reg   <= 32'd0;
        end else if (commit) begin
            case (addr_reg)
                12'h305: mtvec_reg    <= {wdata_reg[31:2], 2'b00};
                12'h340: mscratch_reg <= wdata_reg;
                12'h341: mepc_reg     <= {wdata_reg[31:2], 2'b00};
                12'h342: mcause_reg   <= wdata_reg;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters: a write replaces only the addressed half; the other half
    // still takes the carry of the normal increment.
    // ------------------------------------------------------------------
    logic [63:0] mcycle_inc, minstret_inc;
    logic        wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;

    assign mcycle_inc     = mcycle_reg + 64'd1;
    assign minstret_inc   = minstret_reg + {63'd0, bus.io_retire};
    assign wr_mcycle_lo   = commit && (addr_reg == 12'hB00);
    assign wr_mcycle_hi   = commit && (addr_reg == 12'hB80);
    assign wr_minstret_lo = commit && (addr_reg == 12'hB02);
    assign wr_minstret_hi = commit && (addr_reg == 12'hB82);

    always_comb begin
        mcycle_next   = 64'd0;
        minstret_next = 64'd0;
        if (COUNTERS_EN) begin
            mcycle_next[31:0]    = wr_mcycle_lo   ? wdata_reg : mcycle_inc[31:0];
            mcycle_next[63:32]   = wr_mcycle_hi   ? wdata_reg : mcycle_inc[63:32];
            minstret_next[31:0]  = wr_minstret_lo ? wdata_reg : minstret_inc[31:0];
            minstret_next[63:32] = wr_minstret_hi ? wdata_reg : minstret_inc[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle_reg   <= 64'd0;
            minstret_reg <= 64'd0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.io_busy         = (state_reg != IDLE);
    assign bus.io_resp_valid   = (state_reg == RESP);
    assign bus.io_resp_rdata   = rdata_reg;
    assign bus.io_resp_illegal = illegal_reg;

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

    logic clock;
    logic reset;
    csr_if bus();

    csr_unit #(
        .MTVEC_RESET(32'h0000_0100),
        .COUNTERS_EN(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [31:0] mask;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    localparam logic [2:0] F_RW = 3'd1, F_RS = 3'd2, F_RC = 3'd3,
                           F_RWI = 3'd5, F_RSI = 3'd6, F_RCI = 3'd7;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response strobe pops one expectation.
    always @(negedge clock) begin
        if (bus.io_resp_valid === 1'b1) begin
            exp_t e;
            check("resp_expected", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_rdata"}, bus.io_resp_rdata & e.mask, e.rdata & e.mask);
                check({e.tag, "_illegal"}, {31'd0, bus.io_resp_illegal}, {31'd0, e.illegal});
                $display("resp %s rdata=%h illegal=%b", e.tag, bus.io_resp_rdata, bus.io_resp_illegal);
            end
        end
    end

    task automatic push_exp(input string tag, input logic [31:0] rdata,
                            input logic [31:0] mask, input logic ill);
        exp_t e;
        e.tag = tag; e.rdata = rdata; e.mask = mask; e.illegal = ill;
        sb.push_back(e);
    endtask

    // Called at an IDLE negedge; returns at the next IDLE negedge.
    task automatic do_req(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] idx, input logic [31:0] data,
                          input logic [31:0] exp_rdata, input logic [31:0] mask,
                          input logic exp_ill, input bit retire_in_resp);
        int  n;
        bit  seen;
        bus.io_req_valid    = 1'b1;
        bus.io_req_funct3   = f3;
        bus.io_req_addr     = addr;
        bus.io_req_rs1_idx  = idx;
        bus.io_req_rs1_data = data;
        push_exp(tag, exp_rdata, mask, exp_ill);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clock);
            n++;
            if (bus.io_resp_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, n, 32'd2);
        bus.io_req_valid = 1'b0;
        if (retire_in_resp) bus.io_retire = 1'b1;
        @(negedge clock);
        bus.io_retire = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        reset               = 1'b0;
        bus.io_req_valid    = 1'b0;
        bus.io_req_funct3   = 3'd0;
        bus.io_req_addr     = 12'd0;
        bus.io_req_rs1_idx  = 5'd0;
        bus.io_req_rs1_data = 32'd0;
        bus.io_retire       = 1'b0;
        #1;
        check("rst_busy",    {31'd0, bus.io_busy},         32'd0);
        check("rst_valid",   {31'd0, bus.io_resp_valid},   32'd0);
        check("rst_rdata",   bus.io_resp_rdata,            32'd0);
        check("rst_illegal", {31'd0, bus.io_resp_illegal}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // mscratch write / read with suppressed write
        do_req("mscratch_rw",  F_RW, 12'h340, 5'd1, 32'hDEAD_BEEF, 32'h0,         ALL, 1'b0, 1'b0);
        do_req("mscratch_rs0", F_RS, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, ALL, 1'b0, 1'b0);
        do_req("mscratch_rd",  F_RS, 12'h340, 5'd0, 32'h0,         32'hDEAD_BEEF, ALL, 1'b0, 1'b0);

        // mtvec set/clear
        do_req("mtvec_rsi",  F_RSI, 12'h305, 5'd3, 32'h0,        32'h100, ALL, 1'b0, 1'b0);
        do_req("mtvec_rd1",  F_RS,  12'h305, 5'd0, 32'h0,        32'h100, ALL, 1'b0, 1'b0);
        do_req("mtvec_rc",   F_RC,  12'h305, 5'd5, 32'h100,      32'h100, ALL, 1'b0, 1'b0);
        do_req("mtvec_rd2",  F_RS,  12'h305, 5'd0, 32'h0,        32'h0,   ALL, 1'b0, 1'b0);

        // mepc low bits, mcause immediate write
        do_req("mepc_rw",    F_RW,  12'h341, 5'd2, 32'h1234_5677, 32'h0,         ALL, 1'b0, 1'b0);
        do_req("mepc_rd",    F_RS,  12'h341, 5'd0, 32'h0,         32'h1234_5674, ALL, 1'b0, 1'b0);
        do_req("mcause_rwi", F_RWI, 12'h342, 5'd31, 32'h0,        32'h0,         ALL, 1'b0, 1'b0);
        do_req("mcause_rci", F_RCI, 12'h342, 5'd3, 32'h0,         32'h1F,        ALL, 1'b0, 1'b0);
        do_req("mcause_rd",  F_RS,  12'h342, 5'd0, 32'h0,         32'h1C,        ALL, 1'b0, 1'b0);

        // Illegal requests
        do_req("f3_4",       3'd4,  12'h340, 5'd1, 32'h1,  32'h0, ALL, 1'b1, 1'b0);
        do_req("f3_0",       3'd0,  12'h340, 5'd1, 32'h1,  32'h0, ALL, 1'b1, 1'b0);
        do_req("unmapped",   F_RS,  12'h7C0, 5'd0, 32'h0,  32'h0, ALL, 1'b1, 1'b0);
        // Pin mcycle to a known value, then check the RO shadow rejects writes
        do_req("mcycleh_w0", F_RW,  12'hB80, 5'd1, 32'h0,       32'h0, ALL,   1'b0, 1'b0);
        do_req("mcycle_set", F_RW,  12'hB00, 5'd1, 32'h1000,    32'h0, 32'h0, 1'b0, 1'b0);
        do_req("cycle_rw",   F_RW,  12'hC00, 5'd1, 32'h5555,    32'h0, ALL,   1'b1, 1'b0);
        do_req("cycle_rs0",  F_RS,  12'hC00, 5'd0, 32'hFFFF,    32'h1004, ALL, 1'b0, 1'b0);

        // Counter wrap: high written all-ones, low two below wrap
        do_req("mcycleh_set", F_RW, 12'hB80, 5'd1, 32'hFFFF_FFFF, 32'h0,         ALL,   1'b0, 1'b0);
        do_req("mcycle_near", F_RW, 12'hB00, 5'd1, 32'hFFFF_FFFE, 32'h0,         32'h0, 1'b0, 1'b0);
        do_req("mcycle_rd",   F_RS, 12'hB00, 5'd0, 32'h0,         32'hFFFF_FFFF, ALL,   1'b0, 1'b0);
        do_req("mcycleh_wrap",F_RS, 12'hB80, 5'd0, 32'h0,         32'h0,         ALL,   1'b0, 1'b0);
        do_req("cycleh_wrap", F_RS, 12'hC80, 5'd0, 32'h0,         32'h0,         ALL,   1'b0, 1'b0);

        // minstret: write wins over a retire pulse in the same cycle
        do_req("minstret_w",  F_RW, 12'hB02, 5'd1, 32'h1234, 32'h0,    ALL, 1'b0, 1'b1);
        do_req("minstret_rd", F_RS, 12'hB02, 5'd0, 32'h0,    32'h1234, ALL, 1'b0, 1'b0);
        bus.io_retire = 1'b1;
        @(negedge clock);
        bus.io_retire = 1'b0;
        do_req("instret_rd",  F_RS, 12'hC02, 5'd0, 32'h0,    32'h1235, ALL, 1'b0, 1'b0);
        do_req("instreth_rd", F_RS, 12'hC82, 5'd0, 32'h0,    32'h0,    ALL, 1'b0, 1'b0);

        // Back-to-back: valid held for 9 cycles
        push_exp("hs0", 32'hDEAD_BEEF, ALL, 1'b0);
        push_exp("hs1", 32'hDEAD_BEEF, ALL, 1'b0);
        push_exp("hs2", 32'hDEAD_BEEF, ALL, 1'b0);
        bus.io_req_valid    = 1'b1;
        bus.io_req_funct3   = F_RS;
        bus.io_req_addr     = 12'h340;
        bus.io_req_rs1_idx  = 5'd0;
        bus.io_req_rs1_data = 32'h0;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            check("hs_busy",  {31'd0, bus.io_busy},       {31'd0, ((i % 3) != 0)});
            check("hs_valid", {31'd0, bus.io_resp_valid}, {31'd0, ((i % 3) == 2)});
            if (bus.io_resp_valid === 1'b1) pulses++;
            if (i == 8) bus.io_req_valid = 1'b0;
            @(negedge clock);
        end
        check("hs_pulses", pulses, 32'd3);

        // Reset during ACCESS of a mscratch write
        bus.io_req_valid    = 1'b1;
        bus.io_req_funct3   = F_RW;
        bus.io_req_addr     = 12'h340;
        bus.io_req_rs1_idx  = 5'd1;
        bus.io_req_rs1_data = 32'h0000_0055;
        @(negedge clock);
        check("mid_access_busy", {31'd0, bus.io_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",    {31'd0, bus.io_busy},         32'd0);
        check("mid_rst_valid",   {31'd0, bus.io_resp_valid},   32'd0);
        check("mid_rst_rdata",   bus.io_resp_rdata,            32'd0);
        check("mid_rst_illegal", {31'd0, bus.io_resp_illegal}, 32'd0);
        bus.io_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        do_req("post_rst_mscratch", F_RS, 12'h340, 5'd0, 32'h0, 32'h0,   ALL, 1'b0, 1'b0);
        do_req("post_rst_mtvec",    F_RS, 12'h305, 5'd0, 32'h0, 32'h100, ALL, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file for the RV32I core: the responder for the CSR-class instructions (opcode 0x73, funct3 1–3 and 5–7) that the control decoder flags with regwrite and rs1 use. It takes one CSR request per handshake from the execute stage and performs a two-stage read-modify-write. It returns the old CSR value for writeback to rd and maintains the free-running cycle and retired-instruction counters.

## Interface
- MTVEC_RESET, 32'h0000_0100: reset value of mtvec. Bits [1:0] are forced to 0.
- COUNTERS_EN, 1: when 0, every counter address is illegal and the counters are held at 0.

- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- io_req_valid  in  1  CSR request present; held high until io_resp_valid
- io_req_funct3  in  3  1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI
- io_req_addr  in  12  CSR address
- io_req_rs1_idx  in  5  rs1 index; also zimm for funct3 5–7
- io_req_rs1_data  in  32  rs1 value, used for funct3 1–3
- io_retire  in  1  one pulse per retired instruction
- io_busy  out  1  FSM not in IDLE
- io_resp_valid  out  1  one-cycle response strobe
- io_resp_rdata  out  32  old CSR value; 0 when illegal
- io_resp_illegal  out  1  illegal-instruction flag, valid with io_resp_valid

## Operation
- Supported CSRs:
  - mtvec 0x305: bits [1:0] read as 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read as 0.
  - mcause 0x342.
  - mcycle / mcycleh 0xB00 / 0xB80.
  - minstret / minstreth 0xB02 / 0xB82.
  - Read-only shadows cycle / cycleh 0xC00 / 0xC80 and instret / instreth 0xC02 / 0xC82.
- Operand: src = rs1_data for funct3 1–3; src = {27'b0, rs1_idx} for funct3 5–7.
- New value by class:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Write suppression: RS, RC, RSI and RCI do not write when rs1_idx == 0. RW and RWI always write.
- Illegal when any of the following holds; an illegal request completes with no state change:
  - funct3 is 0 or 4;
  - the address is unmapped;
  - the address has addr[11:10] == 2'b11 (read-only) and the write is not suppressed;
  - the address is a counter and COUNTERS_EN == 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: when io_req_valid is high, latch all io_req_* and go to ACCESS.
  - ACCESS: read the old value into a result register, compute the new value and the illegal flag, go to RESP.
  - RESP: assert io_resp_valid; commit the write if legal and not suppressed; go to IDLE.
- Counters:
  - mcycle (64-bit) increments every cycle after reset.
  - minstret (64-bit) increments on each io_retire pulse.
  - Both wrap from 0xFFFF_FFFF_FFFF_FFFF to 0. Carry propagates from the low word into the high word.
- A CSR write in RESP overrides that cycle's increment of the written half only. The other half keeps its normal carry behaviour.

## Timing
- Reset (async assert) gives the following, with outputs forced low immediately:
  - FSM in IDLE;
  - mscratch, mepc, mcause, mcycle and minstret = 0;
  - mtvec = MTVEC_RESET;
  - io_busy, io_resp_valid, io_resp_illegal = 0; io_resp_rdata = 0.
- Latency: request accepted at edge T (IDLE, valid = 1). io_resp_valid is high during cycle T+2 for exactly one cycle.
- io_busy is high in ACCESS and RESP.
- io_resp_rdata and io_resp_illegal hold their value until the next response.
- Reads of mcycle sample the value in the ACCESS cycle.
- io_req_* are ignored outside IDLE.
- If io_req_valid is still high in the cycle after RESP, it is treated as a new request. Back-to-back throughput is one request per 3 cycles.
- A write takes effect from the edge ending RESP and is visible to the next request's ACCESS.
- Reset asserted mid-operation aborts the access: no write is committed and no response is issued.
- io_retire arriving while busy still increments minstret, unless that same cycle is a minstret write.

## Test plan
- Write then read mscratch:
  - Send CSRRW 0x340 with rs1_data = 0xDEADBEEF -> rdata 0, resp_valid at T+2.
  - Then send CSRRS 0x340 with rs1_idx = 0 -> rdata 0xDEADBEEF and no write.
- Set/clear on mtvec after reset with MTVEC_RESET = 0x100:
  - CSRRSI 0x305 with zimm = 3 -> rdata 0x100; mtvec now reads 0x100 (low bits forced).
  - CSRRC with rs1_data = 0x100 -> subsequent read returns 0.
- Illegal requests:
  - funct3 = 4 -> illegal = 1, rdata = 0.
  - CSRRW to 0xC00 -> illegal = 1 and mcycle is unaffected.
  - CSRRS to 0xC00 with rs1_idx = 0 -> legal.
- Counter wrap and write precedence:
  - CSRRW 0xB80 = 0xFFFFFFFF, then CSRRW 0xB00 = 0xFFFFFFFE; after 3 further cycles mcycleh reads 0 (wrapped).
  - Pulse io_retire in the minstret write cycle -> the written value wins.
- Handshake:
  - Hold io_req_valid high for 9 cycles -> exactly 3 resp_valid pulses, 3 cycles apart; io_busy = 0 only in the acceptance cycles.
- Reset mid-operation:
  - Assert reset in ACCESS of a CSRRW to mscratch -> outputs go to 0 immediately, no response is issued, and mscratch reads 0 afterwards.
